// File: rtl/binary_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional two's-complement input handling is enabled by defining BCD_SIGNED_EN.
module binary_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin_in,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd_out
`ifdef BCD_SIGNED_EN
  ,
  output logic                sign_out
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_sh;
  logic [WIDTH-1:0] operand;
  logic [BW-1:0]    scratch_q;
  logic [BW-1:0]    scratch_adj;
  logic [BW-1:0]    scratch_sh;
  logic [BW-1:0]    bcd_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
`ifdef BCD_SIGNED_EN
  logic             sign_p_q;
  logic             sign_q;
`endif

  // Add-3 correction on every digit, then one left shift of {scratch, shift reg}.
  always_comb begin
    scratch_adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_sh = {scratch_adj[BW-2:0], shreg_q[WIDTH-1]};
    shreg_sh   = shreg_q << 1;
  end

  always_comb begin
`ifdef BCD_SIGNED_EN
    operand = bin_in[WIDTH-1] ? -bin_in : bin_in;
`else
    operand = bin_in;
`endif
    accept = start && ((state_q == IDLE) || (state_q == DONE));
  end

  // Accept handling sits after the case so DONE can restart without a duplicated branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_p_q  <= 1'b0;
      sign_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        SHIFT: begin
          scratch_q <= scratch_sh;
          shreg_q   <= shreg_sh;
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          bcd_q   <= scratch_q;
          done_q  <= 1'b1;
`ifdef BCD_SIGNED_EN
          sign_q  <= sign_p_q;
`endif
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (accept) begin
        shreg_q   <= operand;
        scratch_q <= '0;
        cnt_q     <= CW'(WIDTH);
        state_q   <= SHIFT;
        busy_q    <= 1'b1;
`ifdef BCD_SIGNED_EN
        sign_p_q  <= bin_in[WIDTH-1];
`endif
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
`ifdef BCD_SIGNED_EN
  assign sign_out = sign_q;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed, scoreboard-based bench for binary_to_bcd_seq (8-bit/3-digit and 4-bit/2-digit builds).
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8 = 1'b1, start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        busy8, done8;
  logic [11:0] bcd8;
  logic        rst4 = 1'b1, start4 = 1'b0;
  logic [3:0]  bin4 = '0;
  logic        busy4, done4;
  logic [7:0]  bcd4;
`ifdef BCD_SIGNED_EN
  logic        sign8, sign4;
`endif

  binary_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8)
`ifdef BCD_SIGNED_EN
    , .sign_out(sign8)
`endif
  );

  binary_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .bcd_out(bcd4)
`ifdef BCD_SIGNED_EN
    , .sign_out(sign4)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  logic [12:0] q8[$];
  logic [12:0] q4[$];
  logic [12:0] last8 = '0, last4 = '0;
  logic [12:0] e8, e4;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division; sign bit at [12].
  function automatic logic [12:0] model(input int unsigned v, input int unsigned w,
                                        input int unsigned d);
    int unsigned mag;
    logic        s;
    logic [11:0] r;
    mag = v % (32'd1 << w);
    s   = 1'b0;
    r   = '0;
`ifdef BCD_SIGNED_EN
    if (mag >= (32'd1 << (w - 1))) begin
      s   = 1'b1;
      mag = (32'd1 << w) - mag;
    end
`endif
    for (int unsigned i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return {s, r};
  endfunction

  function automatic logic [12:0] obs8();
`ifdef BCD_SIGNED_EN
    return {sign8, bcd8};
`else
    return {1'b0, bcd8};
`endif
  endfunction

  function automatic logic [12:0] obs4();
`ifdef BCD_SIGNED_EN
    return {sign4, 4'b0, bcd4};
`else
    return {1'b0, 4'b0, bcd4};
`endif
  endfunction

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        check("bcd8", {3'b0, obs8()}, {3'b0, e8});
        last8 = e8;
      end else begin
        check("spurious_done8", 16'(done8), 16'd0);
      end
    end
    if (done4) begin
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        check("bcd4", {3'b0, obs4()}, {3'b0, e4});
        last4 = e4;
      end else begin
        check("spurious_done4", 16'(done4), 16'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done8 : done4;
  endfunction

  function automatic logic [12:0] held_of(input int sel);
    return (sel == 0) ? (obs8() ^ last8) : (obs4() ^ last4);
  endfunction

  task automatic expect_done_after(input int sel, input int n, input string tag);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i < n) check({tag, "_early"}, 16'(done_of(sel)), 16'd0);
      else       check({tag, "_done"},  16'(done_of(sel)), 16'd1);
    end
  endtask

  task automatic expect_quiet(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_nodone"}, 16'(done_of(sel)), 16'd0);
      check({tag, "_held"}, 16'(held_of(sel)), 16'd0);
    end
  endtask

  initial begin
    int vals4[6] = '{0, 11, 15, 3, 9, 5};

    rst8 = 1'b1; rst4 = 1'b1;
    tick(); tick();
    check("rst_busy8", 16'(busy8), 16'd0);
    check("rst_done8", 16'(done8), 16'd0);
    check("rst_bcd8",  16'(bcd8),  16'h000);
    check("rst_busy4", 16'(busy4), 16'd0);
    check("rst_bcd4",  16'(bcd4),  16'h00);
    rst8 = 1'b0; rst4 = 1'b0;
    tick();

    // Single conversion of 255: 8 busy cycles, one idle DONE cycle, then the done pulse.
    bin8 = 8'd255; start8 = 1'b1;
    tick();
    q8.push_back(model(255, 8, 3));
    start8 = 1'b0;
    check("t2_busy0", 16'(busy8), 16'd1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t2_busy", 16'(busy8), 16'd1);
      check("t2_nodone", 16'(done8), 16'd0);
    end
    tick();
    check("t2_busy_off", 16'(busy8), 16'd0);
    check("t2_predone", 16'(done8), 16'd0);
    tick();
    check("t2_done", 16'(done8), 16'd1);
    tick();
    check("t2_pulse", 16'(done8), 16'd0);

    // Back-to-back with start held: 0 then 128.
    bin8 = 8'd0; start8 = 1'b1;
    tick();
    q8.push_back(model(0, 8, 3));
    bin8 = 8'd128;
    expect_done_after(0, 9, "t3a");
    check("t3_restart_busy", 16'(busy8), 16'd1);
    q8.push_back(model(128, 8, 3));
    start8 = 1'b0;
    expect_done_after(0, 9, "t3b");
    tick();
    check("t3_idle", 16'(busy8), 16'd0);

    // Start while busy is ignored.
    bin8 = 8'd73; start8 = 1'b1;
    tick();
    q8.push_back(model(73, 8, 3));
    start8 = 1'b0;
    tick(); tick();
    bin8 = 8'd99; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    expect_done_after(0, 6, "t4");
    expect_quiet(0, 12, "t4_quiet");

    // Reset during the 4th SHIFT cycle aborts the conversion.
    bin8 = 8'd200; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    check("t5_busy_pre", 16'(busy8), 16'd1);
    rst8 = 1'b1;
    tick();
    rst8 = 1'b0;
    last8 = '0;
    check("t5_busy", 16'(busy8), 16'd0);
    check("t5_done", 16'(done8), 16'd0);
    check("t5_bcd",  16'(bcd8),  16'h000);
    expect_quiet(0, 12, "t5_quiet");
    bin8 = 8'd11; start8 = 1'b1;
    tick();
    q8.push_back(model(11, 8, 3));
    start8 = 1'b0;
    expect_done_after(0, 9, "t5b");

    // Reset and start together: reset wins.
    rst8 = 1'b1; start8 = 1'b1; bin8 = 8'd5;
    tick();
    rst8 = 1'b0; start8 = 1'b0;
    last8 = '0;
    check("rs_busy", 16'(busy8), 16'd0);
    expect_quiet(0, 12, "rs_quiet");

`ifdef BCD_SIGNED_EN
    bin8 = 8'h80; start8 = 1'b1;
    tick();
    q8.push_back(model(32'h80, 8, 3));
    start8 = 1'b0;
    expect_done_after(0, 9, "s80");
    bin8 = 8'hFF; start8 = 1'b1;
    tick();
    q8.push_back(model(32'hFF, 8, 3));
    start8 = 1'b0;
    expect_done_after(0, 9, "sFF");
`endif

    // 4-bit / 2-digit instance.
    for (int i = 0; i < 6; i++) begin
      bin4 = 4'(vals4[i]); start4 = 1'b1;
      tick();
      q4.push_back(model(vals4[i], 4, 2));
      start4 = 1'b0;
      expect_done_after(1, 5, "w4");
    end

    tick(); tick();
    check("q8_drained", 16'(q8.size()), 16'd0);
    check("q4_drained", 16'(q4.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
